// File: rtl/cbc_decrypt_logic_pkg.sv
// Shared types and reset constants for the CBC decryption wrapper.
// Block width, controller state encoding and register reset values.
package cbc_pkg;
  localparam int BLOCK_W = 128;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    OUTPUT
  } cbc_dec_state_t;

  localparam cbc_dec_state_t RST_STATE = IDLE;
  localparam block_t         RST_BLOCK = '0;
  localparam logic           RST_FLAG  = 1'b0;
endpackage

// File: rtl/cbc_decrypt_logic_if.sv
// Ciphertext-in / plaintext-out stream handshakes of the CBC wrapper.
// master drives blocks and consumes plaintext; slave is the wrapper.
interface cbc_decrypt_logic_if;
  import cbc_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t ciphertext;
  block_t key;
  block_t iv;
  logic   new_message;
  logic   out_valid;
  logic   out_ready;
  block_t plaintext;

  modport master (
    output in_valid,
    output ciphertext,
    output key,
    output iv,
    output new_message,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  plaintext
  );

  modport slave (
    input  in_valid,
    input  ciphertext,
    input  key,
    input  iv,
    input  new_message,
    input  out_ready,
    output in_ready,
    output out_valid,
    output plaintext
  );
endinterface

// File: rtl/cbc_decrypt_logic.sv
// CBC decryption wrapper around an external AES-128 inverse core:
// P_i = D_K(C_i) ^ C_(i-1), with watchdog on the core's completion.
module cbc_decrypt_logic
  import cbc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  cbc_decrypt_logic_if.slave bus,
  output logic [CNT_W-1:0]   block_count,
  output logic               err,
  output logic               aes_start,
  output block_t             aes_ciphertext,
  output block_t             aes_key,
  input  logic               aes_done,
  input  block_t             aes_plaintext
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  cbc_dec_state_t   r_state;
  block_t           r_prev_ct;
  block_t           r_cur_ct;
  block_t           r_key;
  block_t           r_pt;
  logic [WD_W-1:0]  r_wd_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_start;
  logic             r_out_valid;

  logic w_accept;
  logic w_xfer;
  logic w_timeout;

  // in_ready is held low for the whole time rst is asserted
  assign bus.in_ready = (r_state == IDLE) & ~rst;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_xfer       = r_out_valid & bus.out_ready;
  assign w_timeout    = (r_wd_cnt == WD_LAST);

  assign bus.out_valid  = r_out_valid;
  assign bus.plaintext  = r_pt;
  assign block_count    = r_cnt;
  assign err            = r_err;
  assign aes_start      = r_start;
  assign aes_ciphertext = r_cur_ct;
  assign aes_key        = r_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RST_STATE;
      r_prev_ct   <= RST_BLOCK;
      r_cur_ct    <= RST_BLOCK;
      r_key       <= RST_BLOCK;
      r_pt        <= RST_BLOCK;
      r_wd_cnt    <= '0;
      r_cnt       <= '0;
      r_err       <= RST_FLAG;
      r_start     <= RST_FLAG;
      r_out_valid <= RST_FLAG;
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cur_ct <= bus.ciphertext;
            r_key    <= bus.key;
            if (bus.new_message) begin
              r_prev_ct <= bus.iv;
              r_cnt     <= '0;
              r_err     <= 1'b0;
            end
            r_start <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          r_wd_cnt <= '0;
          r_state  <= WAIT;
        end
        WAIT: begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
          // completion wins over a watchdog expiring in the same cycle
          if (aes_done) begin
            r_pt        <= aes_plaintext ^ r_prev_ct;
            r_prev_ct   <= r_cur_ct;
            r_out_valid <= 1'b1;
            r_state     <= OUTPUT;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end
        end
        OUTPUT: begin
          if (w_xfer) begin
            r_out_valid <= 1'b0;
            r_cnt       <= r_cnt + 1'b1;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
